// File: rtl/tdc_readout_arbiter.sv
// Round-robin arbiter sharing one show-ahead timestamp FIFO between
// TDC channels; entries are tagged with the granted channel index.
module tdc_readout_arbiter #(
  parameter int NCHAN  = 4,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  localparam int IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int ENT_W = IDX_W + DATA_W
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic [NCHAN-1:0]        ch_valid_i,
  input  logic [NCHAN*DATA_W-1:0] ch_data_i,
  output logic [NCHAN-1:0]        ch_ready_o,
  input  logic                    rd_en_i,
  output logic [ENT_W-1:0]        rd_data_o,
  output logic                    rd_empty_o,
  output logic [CNT_W-1:0]        level_o,
  output logic [7:0]              drop_cnt_o,
  input  logic                    clr_drop_i
);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] level;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_next;
  logic [ENT_W-1:0] wr_entry;
  logic [7:0]       drop_cnt;
  logic             full;
  logic             empty;
  logic             any_valid;
  logic             push;
  logic             pop;
  logic             drop_ev;
  int               idx;

  assign full      = (level == CNT_W'(DEPTH));
  assign empty     = (level == '0);
  assign any_valid = |ch_valid_i;

  // Rotating search starting at rr_ptr
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NCHAN) idx = idx - NCHAN;
      if (ch_valid_i[IDX_W'(idx)]) grant = IDX_W'(idx);
    end
  end

  // Reset gates ready so it drops without waiting for an edge
  assign push = enable_i & ~full & ~flush_i & any_valid & ~wb_rst_i;
  assign pop  = rd_en_i & ~empty & ~flush_i;

  assign drop_ev = enable_i & full & ~flush_i & any_valid;

  assign ch_ready_o = push ? (NCHAN'(1) << grant) : '0;

  assign wr_entry = {grant, ch_data_i[int'(grant)*DATA_W +: DATA_W]};

  assign rr_next = (grant == IDX_W'(NCHAN - 1)) ? '0
                 : grant + IDX_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      drop_cnt <= '0;
    end else if (clr_drop_i) begin
      drop_cnt <= '0;
    end else if (drop_ev && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign rd_data_o  = empty ? '0 : mem[rd_ptr];
  assign rd_empty_o = empty;
  assign level_o    = level;
  assign drop_cnt_o = drop_cnt;

endmodule
